syn_gpu_mul_bus_responder: RTL
==============================

SYN_GPU_MUL_BUS_RESPONDER -- requirements
Module: syn_gpu_mul_bus_responder

Interface
REQ-001 Ports SHALL be, in order: cr_intf.clk_ir input 1 (sole clock, rising edge); cr_intf.rst_sync_l input 1 (asynchronous, active-low reset).
REQ-002 mul_bus_intf.anti_alias_sid input sid_t: request type, one of SID_IDLE, SID_MUL or SID_DIV.
REQ-003 mul_bus_intf.anti_alias_req_data input 32: request operands; A = [31:16], B = [15:0].
REQ-004 mul_bus_intf.anti_alias_req_rdy output 1: one-cycle pulse acknowledging request acceptance.
REQ-005 mul_bus_intf.anti_alias_res_valid output 1: one-cycle pulse qualifying res.
REQ-006 mul_bus_intf.anti_alias_res output 32: result; held stable between pulses.

Function
REQ-007 FSM states SHALL be IDLE_S, MUL_S, DIV_S and RES_S.
REQ-008 Acceptance: a request is accepted only in IDLE_S with sid != SID_IDLE; cycle N is the cycle sid is sampled non-idle.
REQ-009 On acceptance, the block SHALL latch A, B and the op, and drive req_rdy high in cycle N+1 only.
REQ-010 Next state on acceptance: SID_MUL -> MUL_S; SID_DIV -> DIV_S; any other code -> RES_S with res = 0.
REQ-011 MUL_S: res <= A*B as an unsigned 16x16 product with full 32-bit result, no truncation; then RES_S; res_valid high in cycle N+2.
REQ-012 DIV_S: run a 16-iteration unsigned restoring division, one quotient bit per cycle, MSB first.
REQ-013 Division result: res[15:0] = quotient, res[31:16] = remainder; res_valid high in cycle N+17.
REQ-014 Divide by zero (B = 0): res = {A, 16'hFFFF}, with the same N+17 latency as a normal division.
REQ-015 RES_S: res_valid high for exactly one cycle, then return to IDLE_S; no new acceptance is allowed in RES_S.
REQ-016 req_rdy and res_valid SHALL never be high in the same cycle, and res_valid SHALL follow req_rdy by at least one cycle.
REQ-017 Changes to sid or req_data while in MUL_S, DIV_S or RES_S SHALL be ignored; only the latched operands are used.
REQ-018 No-reaccept rule: the initiator drops sid the cycle after req_rdy. The block SHALL therefore never re-accept the same request.
REQ-019 Back-to-back: a new request presented in the cycle after res_valid SHALL be accepted in that cycle (IDLE_S).

Reset
REQ-020 While rst_sync_l is low: req_rdy = 0, res_valid = 0, res = 0, state = IDLE_S, iteration counter = 0, latched operands = 0.
REQ-021 Reset asserted mid-operation SHALL abort the operation with no res_valid pulse.
REQ-022 The first acceptance SHALL be possible in the first cycle after reset deassertion.

Configuration
REQ-023 Macro SYN_GPU_MUL_BUS_DIV_EN compiles the divider in.
REQ-024 With SYN_GPU_MUL_BUS_DIV_EN defined: SID_DIV behaves per REQ-012 to REQ-014.
REQ-025 Without SYN_GPU_MUL_BUS_DIV_EN: DIV_S and the divider are absent; SID_DIV goes to RES_S with res = 32'hFFFF_FFFF and res_valid in cycle N+2.

Structure
REQ-026 Package syn_gpu_pkg SHALL hold the sid_t enum (SID_IDLE, SID_MUL, SID_DIV), P_16B_W, P_32B_W and P_MUL_BUS_DIV_ITER = 16.
REQ-027 The divider SHALL be a separate sub-module, syn_gpu_restoring_div16, with ports: start, dividend, divisor, quotient, remainder, done.
REQ-028 syn_gpu_restoring_div16 SHALL be instantiated only under SYN_GPU_MUL_BUS_DIV_EN.
REQ-029 The multiplier SHALL be inferred inline.

Verification
REQ-030 Multiply: SID_MUL with req_data = 32'h0003_0007 -> req_rdy at N+1, res_valid at N+2, res = 32'h0000_0015.
REQ-031 Multiply full width: 32'hFFFF_FFFF with SID_MUL -> res = 32'hFFFE_0001; no overflow and no truncation.
REQ-032 Divide: SID_DIV with 32'h03E8_0007 (1000/7) -> res_valid at N+17, res = 32'h0006_008E.
REQ-033 Divide by zero: SID_DIV with 32'h1234_0000 -> res = 32'h1234_FFFF at N+17.
REQ-034 Anti-alias pattern: SID_MUL 32'h0040_00C8, then SID_DIV {product[15:0], 16'h0064} issued the cycle after res_valid.
REQ-035 Expected for REQ-034: exactly two req_rdy and two res_valid pulses, no coincidence, final res = 32'h0000_0080.
REQ-036 Reset at N+8 of a division -> all outputs 0 at once and no res_valid.
REQ-037 After the REQ-036 reset: a new SID_MUL completes normally.

Source files
------------

// File: rtl/syn_gpu_pkg.sv
// Shared types and widths for the multiply/divide bus responder.
package syn_gpu_pkg;

  localparam int P_16B_W            = 16;
  localparam int P_32B_W            = 32;
  localparam int P_MUL_BUS_DIV_ITER = 16;

  typedef enum logic [1:0] {
    SID_IDLE = 2'd0,
    SID_MUL  = 2'd1,
    SID_DIV  = 2'd2
  } sid_t;

endpackage

// File: rtl/syn_gpu_restoring_div16.sv
// 16-bit unsigned restoring divider, one quotient bit per cycle, MSB first.
// The first iteration runs on the start edge, so done pulses 16 cycles after start.
module syn_gpu_restoring_div16
  import syn_gpu_pkg::*;
(
  input  logic               clk_ir,
  input  logic               rst_sync_l,
  input  logic               start,
  input  logic [P_16B_W-1:0] dividend,
  input  logic [P_16B_W-1:0] divisor,
  output logic [P_16B_W-1:0] quotient,
  output logic [P_16B_W-1:0] remainder,
  output logic               done
);

  localparam int CNT_W = $clog2(P_MUL_BUS_DIV_ITER) + 1;

  logic [P_16B_W-1:0] rem_reg, quo_reg, dsr_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               done_reg;

  logic [P_16B_W-1:0] step_rem, step_quo, step_dsr, rem_next, quo_next;
  logic [P_16B_W:0]   shifted, diff;

  // A zero divisor never restores, which yields quotient 16'hFFFF and remainder = dividend.
  always_comb begin
    step_rem = start ? '0 : rem_reg;
    step_quo = start ? dividend : quo_reg;
    step_dsr = start ? divisor : dsr_reg;
    shifted  = {step_rem, step_quo[P_16B_W-1]};
    diff     = shifted - {1'b0, step_dsr};
    if (diff[P_16B_W]) begin
      rem_next = shifted[P_16B_W-1:0];
      quo_next = {step_quo[P_16B_W-2:0], 1'b0};
    end else begin
      rem_next = diff[P_16B_W-1:0];
      quo_next = {step_quo[P_16B_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      dsr_reg  <= '0;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        dsr_reg <= divisor;
        cnt_reg <= CNT_W'(P_MUL_BUS_DIV_ITER - 1);
      end else if (cnt_reg != '0) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) done_reg <= 1'b1;
      end
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;
  assign done      = done_reg;

endmodule

// File: rtl/syn_gpu_mul_bus_responder.sv
// Bus responder: accepts MUL/DIV requests, returns a 32-bit result with a valid pulse.
// Define SYN_GPU_MUL_BUS_DIV_EN to build in the restoring divider.
module syn_gpu_mul_bus_responder
  import syn_gpu_pkg::*;
(
  input  logic               clk_ir,
  input  logic               rst_sync_l,
  input  sid_t               anti_alias_sid,
  input  logic [P_32B_W-1:0] anti_alias_req_data,
  output logic               anti_alias_req_rdy,
  output logic               anti_alias_res_valid,
  output logic [P_32B_W-1:0] anti_alias_res
);

`ifdef SYN_GPU_MUL_BUS_DIV_EN
  typedef enum logic [1:0] {IDLE_S, MUL_S, DIV_S, RES_S} state_t;
`else
  typedef enum logic [1:0] {IDLE_S, MUL_S, RES_S} state_t;
`endif

  state_t             state_reg;
  sid_t               op_reg;
  logic [P_16B_W-1:0] a_reg, b_reg;
  logic               req_rdy_reg, res_valid_reg;
  logic [P_32B_W-1:0] res_reg;

`ifdef SYN_GPU_MUL_BUS_DIV_EN
  logic               div_start, div_done;
  logic [P_16B_W-1:0] div_quo, div_rem;

  // The divider captures operands on the acceptance edge itself to meet the N+17 latency.
  assign div_start = (state_reg == IDLE_S) && (anti_alias_sid == SID_DIV);

  syn_gpu_restoring_div16 u_div (
    .clk_ir     (clk_ir),
    .rst_sync_l (rst_sync_l),
    .start      (div_start),
    .dividend   (anti_alias_req_data[P_32B_W-1:P_16B_W]),
    .divisor    (anti_alias_req_data[P_16B_W-1:0]),
    .quotient   (div_quo),
    .remainder  (div_rem),
    .done       (div_done)
  );
`endif

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      state_reg     <= IDLE_S;
      op_reg        <= SID_IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      req_rdy_reg   <= 1'b0;
      res_valid_reg <= 1'b0;
      res_reg       <= '0;
    end else begin
      req_rdy_reg <= 1'b0;
      case (state_reg)
        IDLE_S: begin
          if (anti_alias_sid != SID_IDLE) begin
            a_reg       <= anti_alias_req_data[P_32B_W-1:P_16B_W];
            b_reg       <= anti_alias_req_data[P_16B_W-1:0];
            op_reg      <= anti_alias_sid;
            req_rdy_reg <= 1'b1;
            case (anti_alias_sid)
              SID_MUL: state_reg <= MUL_S;
`ifdef SYN_GPU_MUL_BUS_DIV_EN
              SID_DIV: state_reg <= DIV_S;
`endif
              default: state_reg <= RES_S;
            endcase
          end
        end
        MUL_S: begin
          res_reg       <= P_32B_W'(a_reg) * P_32B_W'(b_reg);
          res_valid_reg <= 1'b1;
          state_reg     <= RES_S;
        end
`ifdef SYN_GPU_MUL_BUS_DIV_EN
        DIV_S: begin
          if (div_done) begin
            res_reg       <= {div_rem, div_quo};
            res_valid_reg <= 1'b1;
            state_reg     <= RES_S;
          end
        end
`endif
        RES_S: begin
          // Entered directly from acceptance: spend one cycle to separate valid from rdy.
          if (res_valid_reg) begin
            res_valid_reg <= 1'b0;
            state_reg     <= IDLE_S;
          end else begin
            res_reg       <= (op_reg == SID_DIV) ? '1 : '0;
            res_valid_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE_S;
      endcase
    end
  end

  assign anti_alias_req_rdy   = req_rdy_reg;
  assign anti_alias_res_valid = res_valid_reg;
  assign anti_alias_res       = res_reg;

endmodule
